// File: rtl/product_drain_serializer.sv
// product_drain_serializer
//   Captures one DIM_C x DIM_A product matrix through a valid/ready handshake
//   and streams it out one element per accepted beat, row-major (c outer,
//   a inner), tagged with its (c, a) coordinates and a last flag. A matrix
//   offered during the final beat is captured in that same cycle, so
//   consecutive matrices drain without a bubble.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   mat_valid/ready  matrix input handshake (mat_ready is combinational)
//   mat              packed product matrix, mat[c][a]
//   elem_valid/ready element output handshake
//   elem_data        mat[c][a] of the element being presented
//   elem_c, elem_a   coordinates of the presented element
//   elem_last        presented element is (DIM_C-1, DIM_A-1)
//   frames_done      count of fully drained matrices, wraps

`ifndef DIM_A
`define DIM_A 4
`endif
`ifndef DIM_C
`define DIM_C 4
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 12
`endif

module product_drain_serializer #(
  parameter int DIM_A      = `DIM_A,
  parameter int DIM_C      = `DIM_C,
  parameter int ACC_WIDTH  = `ACC_WIDTH,
  parameter int FCNT_WIDTH = 16,
  localparam int CW = (DIM_C > 1) ? $clog2(DIM_C) : 1,
  localparam int AW = (DIM_A > 1) ? $clog2(DIM_A) : 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       mat_valid,
  output logic                                       mat_ready,
  input  logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] mat,
  output logic                                       elem_valid,
  input  logic                                       elem_ready,
  output logic [ACC_WIDTH-1:0]                       elem_data,
  output logic [CW-1:0]                              elem_c,
  output logic [AW-1:0]                              elem_a,
  output logic                                       elem_last,
  output logic [FCNT_WIDTH-1:0]                      frames_done
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  localparam logic [CW-1:0] C_MAX = CW'(DIM_C - 1);
  localparam logic [AW-1:0] A_MAX = AW'(DIM_A - 1);

  logic [0:0]                                 state_q, state_d;
  logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] buf_q, buf_d;
  logic [CW-1:0]                              c_q, c_d;
  logic [AW-1:0]                              a_q, a_d;
  logic [FCNT_WIDTH-1:0]                      frames_q, frames_d;

  logic draining;
  logic at_last;
  logic beat;
  logic capture;

  assign draining = (state_q == ST_DRAIN);
  assign at_last  = draining && (c_q == C_MAX) && (a_q == A_MAX);
  assign beat     = draining && elem_ready;

  // The buffer is free either when idle or when its final element is
  // leaving this very cycle; that second case is what removes the bubble.
  assign mat_ready = !rst && (!draining || (at_last && elem_ready));
  assign capture   = mat_valid && mat_ready;

  assign elem_valid  = draining;
  assign elem_data   = buf_q[c_q][a_q];
  assign elem_c      = c_q;
  assign elem_a      = a_q;
  assign elem_last   = at_last;
  assign frames_done = frames_q;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    state_d  = state_q;
    buf_d    = buf_q;
    c_d      = c_q;
    a_d      = a_q;
    frames_d = frames_q;

    if (beat && at_last) begin
      frames_d = frames_q + 1'b1;
    end

    if (capture) begin
      buf_d   = mat;
      c_d     = '0;
      a_d     = '0;
      state_d = ST_DRAIN;
    end else if (beat) begin
      if (at_last) begin
        state_d = ST_IDLE;
      end else if (a_q == A_MAX) begin
        a_d = '0;
        c_d = c_q + 1'b1;
      end else begin
        a_d = a_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      // NOTE: the capture buffer is cleared on reset on purpose, so that
      // elem_data reads zero straight out of reset.
      buf_q    <= '0;
      c_q      <= '0;
      a_q      <= '0;
      frames_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge.
      state_q  <= state_d;
      buf_q    <= buf_d;
      c_q      <= c_d;
      a_q      <= a_d;
      frames_q <= frames_d;
    end
  end

endmodule

// File: tb/tb_product_drain_serializer.sv
// Directed bench for product_drain_serializer: a 2x2 instance for the main
// drain, stall, back-to-back, ignored-input and reset scenarios, plus a 1x1
// instance with a 2-bit frame counter for the degenerate size and wrap.
module tb_product_drain_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 2x2 instance
  logic                    mat_valid, mat_ready, elem_valid, elem_ready, elem_last;
  logic [1:0][1:0][11:0]   mat;
  logic [11:0]             elem_data;
  logic [0:0]              elem_c, elem_a;
  logic [15:0]             frames_done;

  product_drain_serializer #(
    .DIM_A(2), .DIM_C(2), .ACC_WIDTH(12), .FCNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .mat_valid(mat_valid), .mat_ready(mat_ready), .mat(mat),
    .elem_valid(elem_valid), .elem_ready(elem_ready),
    .elem_data(elem_data), .elem_c(elem_c), .elem_a(elem_a),
    .elem_last(elem_last), .frames_done(frames_done)
  );

  // 1x1 instance, 2-bit frame counter
  logic                    s_valid, s_ready, s_evalid, s_eready, s_last;
  logic [0:0][0:0][11:0]   s_mat;
  logic [11:0]             s_data;
  logic [0:0]              s_c, s_a;
  logic [1:0]              s_frames;

  product_drain_serializer #(
    .DIM_A(1), .DIM_C(1), .ACC_WIDTH(12), .FCNT_WIDTH(2)
  ) dut_small (
    .clk(clk), .rst(rst),
    .mat_valid(s_valid), .mat_ready(s_ready), .mat(s_mat),
    .elem_valid(s_evalid), .elem_ready(s_eready),
    .elem_data(s_data), .elem_c(s_c), .elem_a(s_a),
    .elem_last(s_last), .frames_done(s_frames)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; all checks and drives happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input string tag, input logic [11:0] d,
                             input int c, input int a, input logic last);
    check({tag, ".valid"}, 32'(elem_valid), 32'd1);
    check({tag, ".data"},  32'(elem_data),  32'(d));
    check({tag, ".c"},     32'(elem_c),     32'(c));
    check({tag, ".a"},     32'(elem_a),     32'(a));
    check({tag, ".last"},  32'(elem_last),  32'(last));
  endtask

  logic [1:0][1:0][11:0] m1, m2, junk;

  initial begin
    m1[0][0] = 12'h001; m1[0][1] = 12'h002; m1[1][0] = 12'h003; m1[1][1] = 12'h004;
    m2[0][0] = 12'hA01; m2[0][1] = 12'hA02; m2[1][0] = 12'hA03; m2[1][1] = 12'hA04;
    junk[0][0] = 12'hBAD; junk[0][1] = 12'hBAD; junk[1][0] = 12'hBAD; junk[1][1] = 12'hBAD;

    rst = 1'b1; mat_valid = 1'b0; mat = '0; elem_ready = 1'b1;
    s_valid = 1'b0; s_mat = '0; s_eready = 1'b1;
    #1;

    // Reset state
    tick(); tick();
    check("rst.mat_ready", 32'(mat_ready), 32'd0);
    check("rst.elem_valid", 32'(elem_valid), 32'd0);
    check("rst.elem_data", 32'(elem_data), 32'd0);
    check("rst.elem_last", 32'(elem_last), 32'd0);
    check("rst.frames", 32'(frames_done), 32'd0);
    rst = 1'b0;
    #1;
    check("idle.mat_ready", 32'(mat_ready), 32'd1);

    // 1. Basic drain
    mat = m1; mat_valid = 1'b1;
    tick();
    mat_valid = 1'b0;
    expect_beat("t1.b0", 12'h001, 0, 0, 1'b0);
    check("t1.b0.mat_ready", 32'(mat_ready), 32'd0);
    tick(); expect_beat("t1.b1", 12'h002, 0, 1, 1'b0);
    tick(); expect_beat("t1.b2", 12'h003, 1, 0, 1'b0);
    tick(); expect_beat("t1.b3", 12'h004, 1, 1, 1'b1);
    check("t1.b3.mat_ready", 32'(mat_ready), 32'd1);
    tick();
    check("t1.end.valid", 32'(elem_valid), 32'd0);
    check("t1.end.frames", 32'(frames_done), 32'd1);

    // 2. Backpressure at (0,1), 4. ignored garbage at (1,0)
    mat = m1; mat_valid = 1'b1;
    tick();
    mat_valid = 1'b0;
    expect_beat("t2.b0", 12'h001, 0, 0, 1'b0);
    tick();
    elem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      expect_beat($sformatf("t2.stall%0d", i), 12'h002, 0, 1, 1'b0);
      check($sformatf("t2.stall%0d.mat_ready", i), 32'(mat_ready), 32'd0);
      tick();
    end
    elem_ready = 1'b1;
    expect_beat("t2.b1", 12'h002, 0, 1, 1'b0);
    tick(); expect_beat("t2.b2", 12'h003, 1, 0, 1'b0);
    mat = junk; mat_valid = 1'b1;
    #1;
    check("t4.mat_ready", 32'(mat_ready), 32'd0);
    tick();
    mat_valid = 1'b0; mat = '0;
    expect_beat("t2.b3", 12'h004, 1, 1, 1'b1);
    tick();
    check("t2.end.valid", 32'(elem_valid), 32'd0);
    check("t2.end.frames", 32'(frames_done), 32'd2);

    // 3. Back-to-back, second matrix held valid through the first drain
    mat = m1; mat_valid = 1'b1;
    tick();
    mat = m2;
    #1;
    expect_beat("t3.b0", 12'h001, 0, 0, 1'b0);
    check("t3.b0.mat_ready", 32'(mat_ready), 32'd0);
    tick(); expect_beat("t3.b1", 12'h002, 0, 1, 1'b0);
    check("t3.b1.mat_ready", 32'(mat_ready), 32'd0);
    tick(); expect_beat("t3.b2", 12'h003, 1, 0, 1'b0);
    check("t3.b2.mat_ready", 32'(mat_ready), 32'd0);
    tick(); expect_beat("t3.b3", 12'h004, 1, 1, 1'b1);
    check("t3.b3.mat_ready", 32'(mat_ready), 32'd1);
    tick();
    mat_valid = 1'b0; mat = '0;
    expect_beat("t3.b4", 12'hA01, 0, 0, 1'b0);
    check("t3.b4.frames", 32'(frames_done), 32'd3);
    tick(); expect_beat("t3.b5", 12'hA02, 0, 1, 1'b0);
    tick(); expect_beat("t3.b6", 12'hA03, 1, 0, 1'b0);
    tick(); expect_beat("t3.b7", 12'hA04, 1, 1, 1'b1);
    tick();
    check("t3.end.valid", 32'(elem_valid), 32'd0);
    check("t3.end.frames", 32'(frames_done), 32'd4);

    // 5. Reset mid-drain
    mat = m1; mat_valid = 1'b1;
    tick();
    mat_valid = 1'b0;
    tick(); expect_beat("t5.b1", 12'h002, 0, 1, 1'b0);
    tick(); expect_beat("t5.b2", 12'h003, 1, 0, 1'b0);
    rst = 1'b1;
    #1;
    check("t5.rst.mat_ready", 32'(mat_ready), 32'd0);
    tick();
    check("t5.rst.valid", 32'(elem_valid), 32'd0);
    check("t5.rst.frames", 32'(frames_done), 32'd0);
    check("t5.rst.data", 32'(elem_data), 32'd0);
    rst = 1'b0;
    #1;
    check("t5.post.mat_ready", 32'(mat_ready), 32'd1);
    mat = m2; mat_valid = 1'b1;
    tick();
    mat_valid = 1'b0;
    expect_beat("t5.new.b0", 12'hA01, 0, 0, 1'b0);
    tick(); tick(); tick(); tick();
    check("t5.new.frames", 32'(frames_done), 32'd1);

    // 6. 1x1 instance: last on every beat, zero-bubble stream, counter wrap
    s_mat[0][0] = 12'h100; s_valid = 1'b1;
    #1;
    check("t6.idle.ready", 32'(s_ready), 32'd1);
    tick();
    check("t6.f0.valid", 32'(s_evalid), 32'd1);
    check("t6.f0.data", 32'(s_data), 32'h100);
    check("t6.f0.last", 32'(s_last), 32'd1);
    check("t6.f0.ready", 32'(s_ready), 32'd1);
    check("t6.f0.frames", 32'(s_frames), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      s_mat[0][0] = 12'(12'h100 + k);
      tick();
      check($sformatf("t6.f%0d.data", k), 32'(s_data), 32'(12'h100 + k));
      check($sformatf("t6.f%0d.ca", k), {30'd0, s_c, s_a}, 32'd0);
      check($sformatf("t6.f%0d.frames", k), 32'(s_frames), 32'(k % 4));
    end
    s_valid = 1'b0;
    tick();
    check("t6.end.valid", 32'(s_evalid), 32'd0);
    check("t6.end.frames", 32'(s_frames), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
